ip_codma_mem_slave: RTL and testbench

Memory-side responder for the CODMA memory interface. It sits directly downstream of the DMA's memory master port and accepts its read/write burst requests. It grants each request after a programmable latency and serves bursts of 64-bit beats from an internal word-addressed array. Illegal requests are answered with a one-cycle error pulse. It is the memory model the cocotb bench attaches to the DMA, and it is also synthesizable as a simple on-chip scratch memory.

---
 rtl/ip_codma_mem_slave.sv | 144 ++++++++++++++
 tb/tb_ip_codma_mem_slave.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ip_codma_mem_slave.sv
// Memory-side responder for CODMA: grants read/write bursts and serves 64-bit beats from an internal array.
// Latency: grant GRANT_LAT cycles after request is sampled; first read beat READ_LAT cycles after grant.
// Backpressure: request is held by master until grant/error; write beats may have gaps; read beats are never stalled.
module ip_codma_mem_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter int GRANT_LAT   = 2,
    parameter int READ_LAT    = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [3:0]  size,
    output logic        grant,
    output logic [63:0] read_data,
    output logic        read_valid,
    input  logic [63:0] write_data,
    input  logic        write_valid,
    output logic        error
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [2:0] {IDLE, WAIT_GRANT, RD_LAT, RD_DATA, WR_DATA} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;       // grant / read latency countdown
    logic [3:0]      beats, beats_nxt;   // beats completed in current burst
    logic [AW-1:0]   word_ptr, ptr_nxt;  // next word to read or write
    logic            dir_rd;
    logic [3:0]      len;
    logic            error_q, err_nxt;
    logic            accept, mem_we, issue;
    logic            req_any, req_held, illegal;
    logic [29:0]     end_word;
    logic [63:0]     rdata_q;
    logic [63:0]     mem [DEPTH_WORDS];

    assign req_any  = read | write;
    assign req_held = dir_rd ? read : write;
    // One-past-last word of the burst; must not exceed the array.
    assign end_word = {1'b0, addr[31:3]} + {26'd0, size};
    assign illegal  = (read & write) | (size == 4'd0) | (addr[2:0] != 3'd0)
                    | (end_word > 30'(DEPTH_WORDS));

    // Next-state, counters and strobes for the burst sequencer.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        beats_nxt = beats;
        ptr_nxt   = word_ptr;
        grant     = 1'b0;
        accept    = 1'b0;
        err_nxt   = 1'b0;
        mem_we    = 1'b0;
        unique case (state)
            IDLE: begin
                // The cycle right after an error the master may still be holding the
                // rejected request; ignore it so the error stays a single pulse.
                if (req_any && !error_q) begin
                    if (illegal) begin
                        err_nxt = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = WAIT_GRANT;
                        cnt_nxt   = 4'(GRANT_LAT - 1);
                        beats_nxt = 4'd0;
                        ptr_nxt   = addr[AW+2:3];
                    end
                end
            end
            WAIT_GRANT: begin
                if (!req_held) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd0) begin
                    grant = 1'b1;
                    if (dir_rd) begin
                        state_nxt = (READ_LAT == 1) ? RD_DATA : RD_LAT;
                        cnt_nxt   = 4'(READ_LAT > 1 ? READ_LAT - 2 : 0);
                    end else begin
                        state_nxt = WR_DATA;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RD_LAT: begin
                if (cnt == 4'd0) state_nxt = RD_DATA;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RD_DATA: begin
                if (beats == len - 4'd1) state_nxt = IDLE;
                else                     beats_nxt = beats + 4'd1;
            end
            WR_DATA: begin
                if (write_valid) begin
                    mem_we  = 1'b1;
                    ptr_nxt = word_ptr + AW'(1);
                    if (beats == len - 4'd1) state_nxt = IDLE;
                    else                     beats_nxt = beats + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A read beat is fetched on the edge that enters each RD_DATA cycle.
        if (state_nxt == RD_DATA) ptr_nxt = word_ptr + AW'(1);
    end

    assign issue = (state_nxt == RD_DATA);

    // Sequencer state, request latch and registered read data.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            beats    <= 4'd0;
            word_ptr <= '0;
            dir_rd   <= 1'b0;
            len      <= 4'd0;
            error_q  <= 1'b0;
            rdata_q  <= 64'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            beats    <= beats_nxt;
            word_ptr <= ptr_nxt;
            error_q  <= err_nxt;
            if (accept) begin
                dir_rd <= read;
                len    <= size;
            end
            if (issue) rdata_q <= mem[word_ptr];
        end
    end

    // Array write port; contents survive reset, but no write lands on a reset edge.
    always_ff @(posedge clk_i) begin
        if (mem_we && !reset_i) mem[word_ptr] <= write_data;
    end

    assign read_valid = (state == RD_DATA);
    assign read_data  = rdata_q;
    assign error      = error_q;
endmodule

// File: tb/tb_ip_codma_mem_slave.sv
// Bench for ip_codma_mem_slave: two instances (default latencies, and GRANT_LAT=1/READ_LAT=3).
// Transactions are checked cycle-exactly against a per-instance word array model.
// Master side holds requests until grant/error and inserts random or patterned write gaps.
module tb_ip_codma_mem_slave;
    logic        clk_i = 1'b0;
    logic        reset_i, read, write, write_valid;
    logic [31:0] addr;
    logic [3:0]  size;
    logic [63:0] write_data;
    bit          sel;

    logic        g0, g1, rv0, rv1, e0, e1;
    logic [63:0] rd0, rd1;
    logic        grant, read_valid, error;
    logic [63:0] read_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int gl, rl;
    int last_beat_cyc;
    logic [63:0] model [2][1024];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    ip_codma_mem_slave #(.DEPTH_WORDS(1024), .GRANT_LAT(2), .READ_LAT(1)) dut0 (
        .clk_i(clk_i), .reset_i(reset_i), .read(read & ~sel), .write(write & ~sel),
        .addr(addr), .size(size), .grant(g0), .read_data(rd0), .read_valid(rv0),
        .write_data(write_data), .write_valid(write_valid & ~sel), .error(e0));

    ip_codma_mem_slave #(.DEPTH_WORDS(64), .GRANT_LAT(1), .READ_LAT(3)) dut1 (
        .clk_i(clk_i), .reset_i(reset_i), .read(read & sel), .write(write & sel),
        .addr(addr), .size(size), .grant(g1), .read_data(rd1), .read_valid(rv1),
        .write_data(write_data), .write_valid(write_valid & sel), .error(e1));

    assign grant      = sel ? g1  : g0;
    assign read_valid = sel ? rv1 : rv0;
    assign error      = sel ? e1  : e0;
    assign read_data  = sel ? rd1 : rd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] s,
                       input bit nowait);
        if (!nowait) begin @(posedge clk_i); #1; end
        read = rd; write = wr; addr = a; size = s;
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (grant) begin
                g = cyc;
                chk("grant_no_err", 64'(error), 64'd0);
                break;
            end
        end
    endtask

    // Scan every cycle after grant: beat k expected at g+rl+k, idle otherwise.
    task automatic rd_tail(input int g, input logic [31:0] a, input logic [3:0] s,
                           input bit keep, input int rst_after);
        int base, w, n;
        base = g + rl; w = int'(a[31:3]); n = int'(s);
        if (!keep) begin @(posedge clk_i); #1; read = 1'b0; write_valid = 1'b0; end
        for (int c = g + 1; c <= base + n; c++) begin
            @(negedge clk_i);
            if (c >= base && c < base + n) begin
                chk("rd_valid", 64'(read_valid), 64'd1);
                chk("rd_data", read_data, model[sel][w + c - base]);
                last_beat_cyc = c;
                if (rst_after > 0 && c == base + rst_after - 1) begin
                    reset_i = 1'b1;
                    @(negedge clk_i);
                    chk("rst_rd_valid", 64'(read_valid), 64'd0);
                    chk("rst_rd_data", read_data, 64'd0);
                    chk("rst_grant", 64'(grant), 64'd0);
                    @(posedge clk_i); #1; reset_i = 1'b0;
                    return;
                end
            end else begin
                chk("rd_idle_valid", 64'(read_valid), 64'd0);
                if (c == base + n) chk("rd_hold", read_data, model[sel][w + n - 1]);
            end
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] s, input bit nowait,
                           input bit keep, input int rst_after);
        int rq, g;
        req(1'b1, 1'b0, a, s, nowait); rq = cyc;
        wait_grant(g);
        chk("rd_grant_lat", 64'(g - rq), 64'(gl));
        if (g < 0) begin read = 1'b0; return; end
        rd_tail(g, a, s, keep, rst_after);
    endtask

    // pat: per-cycle write_valid bits (LSB first); 0 selects random gaps.
    task automatic do_write(input logic [31:0] a, input logic [3:0] s, input logic [15:0] pat,
                            input bit seq, input bit junk);
        int rq, g, sent, idx, w;
        logic [63:0] d;
        req(1'b0, 1'b1, a, s, 1'b0); rq = cyc;
        wait_grant(g);
        chk("wr_grant_lat", 64'(g - rq), 64'(gl));
        if (g < 0) begin write = 1'b0; return; end
        sent = 0; idx = 0; w = int'(a[31:3]); d = '0;
        while (sent < int'(s) && idx < 200) begin
            @(posedge clk_i); #1;
            write = 1'b0;
            d = seq ? 64'(17 * (sent + 1)) : {$urandom, $urandom};
            write_valid = (pat == 16'd0) ? 1'($urandom_range(0, 1)) : pat[idx % 16];
            write_data  = d;
            if (write_valid) begin
                model[sel][w + sent] = d;
                sent++;
            end
            idx++;
        end
        @(posedge clk_i); #1;
        write_valid = junk;
        write_data  = ~d;
    endtask

    task automatic bad_req(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [3:0] s);
        int rq, ne, ng, ec;
        req(rd, wr, a, s, 1'b0); rq = cyc; ne = 0; ng = 0; ec = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (grant) ng++;
            if (error) begin
                ne++; ec = cyc;
                @(posedge clk_i); #1; read = 1'b0; write = 1'b0;
            end
        end
        read = 1'b0; write = 1'b0;
        chk({tag, "_err_cyc"}, 64'(ec - rq), 64'd1);
        chk({tag, "_err_cnt"}, 64'(ne), 64'd1);
        chk({tag, "_grant"}, 64'(ng), 64'd0);
    endtask

    initial begin
        int rq, ng, ne, g2, s, w;
        reset_i = 1'b1; read = 1'b0; write = 1'b0; write_valid = 1'b0;
        addr = '0; size = '0; write_data = '0; sel = 1'b0; gl = 2; rl = 1;
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        for (int k = 0; k < 2; k++) begin
            sel = 1'(k); #1;
            chk("rst_grant", 64'(grant), 64'd0);
            chk("rst_read_valid", 64'(read_valid), 64'd0);
            chk("rst_error", 64'(error), 64'd0);
            chk("rst_read_data", read_data, 64'd0);
        end
        sel = 1'b0;

        // Basic burst write 0x11..0x44 and readback
        do_write(32'h40, 4'd4, 16'hFFFF, 1'b1, 1'b0);
        do_read(32'h40, 4'd4, 1'b0, 1'b0, 0);

        // Gapped write 1,0,0,1,0,1; extra beat ignored; request in the very next cycle
        do_write(32'h100, 4'd3, 16'h0029, 1'b0, 1'b1);
        do_read(32'h100, 4'd3, 1'b1, 1'b0, 0);

        bad_req("ill_size0", 1'b1, 1'b0, 32'h0, 4'd0);
        bad_req("ill_misalign", 1'b0, 1'b1, 32'h44, 4'd1);
        bad_req("ill_range", 1'b1, 1'b0, 32'((1024 - 2) * 8), 4'd3);
        bad_req("ill_both", 1'b1, 1'b1, 32'h0, 4'd1);

        // Top-of-array burst
        do_write(32'((1024 - 4) * 8), 4'd4, 16'd0, 1'b0, 1'b0);
        do_read(32'((1024 - 4) * 8), 4'd4, 1'b0, 1'b0, 0);

        // Request dropped while waiting for grant
        req(1'b1, 1'b0, 32'h40, 4'd4, 1'b0); rq = cyc;
        @(posedge clk_i); #1; read = 1'b0;
        ng = 0; ne = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (grant) ng++;
            if (error) ne++;
        end
        chk("drop_grant", 64'(ng), 64'd0);
        chk("drop_error", 64'(ne), 64'd0);
        do_read(32'h40, 4'd4, 1'b0, 1'b0, 0);

        // Reset after the 2nd of 4 beats, then the data is still there
        do_read(32'h40, 4'd4, 1'b0, 1'b0, 2);
        do_read(32'h40, 4'd4, 1'b0, 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            s = $urandom_range(1, 15);
            w = $urandom_range(0, 1024 - s);
            do_write(32'(w * 8), 4'(s), 16'd0, 1'b0, 1'b0);
            do_read(32'(w * 8), 4'(s), 1'b0, 1'b0, 0);
        end

        // Short-grant / long-read instance with a request held across the burst
        sel = 1'b1; gl = 1; rl = 3;
        do_write(32'h0, 4'd1, 16'hFFFF, 1'b0, 1'b0);
        do_read(32'h0, 4'd1, 1'b0, 1'b1, 0);
        wait_grant(g2);
        chk("b2b_grant", 64'(g2 - last_beat_cyc), 64'(1 + gl));
        if (g2 >= 0) rd_tail(g2, 32'h0, 4'd1, 1'b0, 0);
        read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s = $urandom_range(1, 15);
            w = $urandom_range(0, 64 - s);
            do_write(32'(w * 8), 4'(s), 16'd0, 1'b0, 1'b0);
            do_read(32'(w * 8), 4'(s), 1'b0, 1'b0, 0);
        end
        bad_req("ill_range_small", 1'b0, 1'b1, 32'(60 * 8), 4'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
